prbs_lfsr_gen: RTL and testbench

PRBS_LFSR_GEN -- requirements
Module: prbs_lfsr_gen

---
 rtl/prbs_lfsr_gen_if.sv | 11 +
 rtl/prbs_lfsr_gen.sv | 90 +++++++++
 tb/tb_prbs_lfsr_gen.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/prbs_lfsr_gen_if.sv
// Output stream bus of the PRBS generator: data word plus valid/ready handshake.
interface prbs_lfsr_gen_if #(
  parameter int OUT_W = 1
);
  logic [OUT_W-1:0] m_data;
  logic             m_valid;
  logic             m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/prbs_lfsr_gen.sv
// Fibonacci LFSR pattern generator. It emits OUT_W serial bits per transfer
// on a valid/ready stream. Wrap and all-zero lock-up are flagged as pulses.
module prbs_lfsr_gen #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = 8'b10001110,
  parameter logic [WIDTH-1:0] SEED  = '1,
  parameter int               OUT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  prbs_lfsr_gen_if.master  m_if,
  output logic             wrap,
  output logic             lock_err,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0]            r_state;
  logic [WIDTH-1:0]            r_seed;
  logic [OUT_W-1:0]            r_data;
  logic                        r_valid;
  logic                        r_wrap;
  logic                        r_lock;

  // w_steps[0] is the current state; w_steps[j+1] is the state after j+1 serial steps
  logic [OUT_W:0][WIDTH-1:0]   w_steps;
  logic [OUT_W-1:0]            w_word;
  logic [OUT_W-1:0]            w_hitv;
  logic                        w_hit;
  logic                        w_zero;
  logic                        w_fire;
  logic [WIDTH-1:0]            w_seed_ld;

  assign w_steps[0] = r_state;

  // Unrolled multi-step LFSR: OUT_W serial steps evaluated in a single cycle
  for (genvar j = 0; j < OUT_W; j++) begin : g_step
    assign w_word[j]      = w_steps[j][0];
    assign w_steps[j+1]   = {^(w_steps[j] & POLY), w_steps[j][WIDTH-1:1]};
    assign w_hitv[j]      = (w_steps[j+1] == r_seed);
  end

  assign w_hit     = |w_hitv;
  assign w_zero    = (r_state == '0);
  // A zero state blocks firing so recovery always takes precedence
  assign w_fire    = enable & ~load & ~w_zero & (~r_valid | m_if.m_ready);
  // A zero seed would lock the register up, so the built-in seed replaces it
  assign w_seed_ld = (seed_in == '0) ? SEED : seed_in;

  // Priority order: load, zero-state recovery, fire, drain of the accepted word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SEED;
      r_seed  <= SEED;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
      r_lock  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      r_lock <= 1'b0;
      if (load) begin
        r_state <= w_seed_ld;
        r_seed  <= w_seed_ld;
        r_valid <= 1'b0;
        r_lock  <= (seed_in == '0);
      end else if (w_zero) begin
        r_state <= SEED;
        r_valid <= 1'b0;
        r_lock  <= 1'b1;
      end else if (w_fire) begin
        r_state <= w_steps[OUT_W];
        r_data  <= w_word;
        r_valid <= 1'b1;
        r_wrap  <= w_hit;
      end else if (m_if.m_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign m_if.m_data  = r_data;
  assign m_if.m_valid = r_valid;
  assign wrap         = r_wrap;
  assign lock_err     = r_lock;
  assign state        = r_state;

endmodule

// File: tb/tb_prbs_lfsr_gen.sv
// Bench for prbs_lfsr_gen: 3-stage x^3+x^2+1 style LFSR, serial (OUT_W=1) and 4-bit instances.
// Expected words go into queues; negedge monitors pop them on each transfer.
module tb_prbs_lfsr_gen;

  typedef struct {
    logic [3:0] data;
    logic       wrap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable, load, en4;
  logic [2:0] seed_in;
  logic       wrap, lock_err, wrap4, lock4;
  logic [2:0] state, state4;

  int checks   = 0;
  int failures = 0;

  exp_t q1[$];
  exp_t q4[$];

  always #5 clk = ~clk;

  prbs_lfsr_gen_if #(.OUT_W(1)) mif ();
  prbs_lfsr_gen_if #(.OUT_W(4)) mif4 ();

  prbs_lfsr_gen #(.WIDTH(3), .POLY(3'b011), .SEED(3'b001), .OUT_W(1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .seed_in(seed_in),
    .m_if(mif), .wrap(wrap), .lock_err(lock_err), .state(state)
  );

  prbs_lfsr_gen #(.WIDTH(3), .POLY(3'b011), .SEED(3'b001), .OUT_W(4)) dut4 (
    .clk(clk), .rst(rst), .enable(en4), .load(1'b0), .seed_in(3'b000),
    .m_if(mif4), .wrap(wrap4), .lock_err(lock4), .state(state4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic d, input logic w);
    exp_t e;
    e.data = {3'b000, d};
    e.wrap = w;
    q1.push_back(e);
  endtask

  task automatic push4(input logic [3:0] d, input logic w);
    exp_t e;
    e.data = d;
    e.wrap = w;
    q4.push_back(e);
  endtask

  // Serial-instance monitor: a word is fresh when it was not stalled at the previous sample
  always @(negedge clk) begin : mon1
    static logic stall_prev = 1'b0;
    exp_t e;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (mif.m_valid && mif.m_ready) begin
        if (q1.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word1: got %0h expected none", mif.m_data);
        end else begin
          e = q1.pop_front();
          chk("m_data1", {31'd0, mif.m_data}, {28'd0, e.data});
          chk("wrap1", {31'd0, wrap}, stall_prev ? 32'd0 : {31'd0, e.wrap});
        end
      end
      stall_prev = mif.m_valid && !mif.m_ready;
    end
  end

  // 4-bit-instance monitor
  always @(negedge clk) begin : mon4
    exp_t e;
    if (!rst && mif4.m_valid && mif4.m_ready) begin
      if (q4.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word4: got %0h expected none", mif4.m_data);
      end else begin
        e = q4.pop_front();
        chk("m_data4", {28'd0, mif4.m_data}, {28'd0, e.data});
        chk("wrap4", {31'd0, wrap4}, {31'd0, e.wrap});
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [6:0] seq1;
    logic [6:0] seq4;
    seq1 = 7'b1101001;  // bit k = k-th serial output from 001
    seq4 = 7'b0011101;  // bit k = k-th serial output from 101

    rst = 1'b1; enable = 1'b0; load = 1'b0; seed_in = 3'b000; en4 = 1'b0;
    mif.m_ready = 1'b1; mif4.m_ready = 1'b1;
    repeat (2) tick();
    chk("rst_state", {29'd0, state}, 32'h1);
    chk("rst_valid", {31'd0, mif.m_valid}, 32'h0);
    chk("rst_wrap",  {31'd0, wrap}, 32'h0);
    chk("rst_lock",  {31'd0, lock_err}, 32'h0);
    chk("rst_data",  {31'd0, mif.m_data}, 32'h0);
    rst = 1'b0;
    tick();

    // 4 bits per word: 1001 then 1110 (second word passes through 001 -> wrap)
    push4(4'b1001, 1'b0);
    push4(4'b1110, 1'b1);
    en4 = 1'b1;
    tick();
    chk("state4_w1", {29'd0, state4}, 32'h6);
    tick();
    en4 = 1'b0;
    chk("state4_w2", {29'd0, state4}, 32'h4);
    tick();

    // Two full periods of the serial sequence, wrap on every 7th word
    for (int i = 0; i < 14; i++) push1(seq1[i % 7], (i % 7) == 6);
    enable = 1'b1;
    repeat (14) tick();
    enable = 1'b0;
    tick();
    chk("t1_state_end", {29'd0, state}, 32'h1);

    // Back-pressure on the first word: no advance, no lost bit
    push1(1'b1, 1'b0);
    push1(1'b0, 1'b0);
    enable = 1'b1;
    tick();
    mif.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_data",  {31'd0, mif.m_data}, 32'h1);
      chk("t3_hold_state", {29'd0, state}, 32'h4);
      chk("t3_hold_valid", {31'd0, mif.m_valid}, 32'h1);
    end
    mif.m_ready = 1'b1;
    tick();
    enable = 1'b0;
    tick();
    chk("t3_state_end", {29'd0, state}, 32'h2);
    chk("t3_valid_end", {31'd0, mif.m_valid}, 32'h0);

    // Load wins over an enabled fire; the new seed defines the period
    seed_in = 3'b101;
    load = 1'b1;
    enable = 1'b1;
    tick();
    load = 1'b0;
    enable = 1'b0;
    chk("t4_valid", {31'd0, mif.m_valid}, 32'h0);
    chk("t4_state", {29'd0, state}, 32'h5);
    chk("t4_wrap",  {31'd0, wrap}, 32'h0);
    for (int i = 0; i < 7; i++) push1(seq4[i], i == 6);
    enable = 1'b1;
    repeat (7) tick();
    enable = 1'b0;
    tick();
    chk("t4_state_end", {29'd0, state}, 32'h5);

    // Zero seed is replaced by SEED and flagged
    seed_in = 3'b000;
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("t5_state", {29'd0, state}, 32'h1);
    chk("t5_lock",  {31'd0, lock_err}, 32'h1);
    chk("t5_wrap",  {31'd0, wrap}, 32'h0);
    tick();
    chk("t5_lock_clr", {31'd0, lock_err}, 32'h0);

    // Forced all-zero state recovers to SEED and is flagged
    force dut.r_state = 3'b000;
    #1;
    release dut.r_state;
    chk("t5_forced", {29'd0, state}, 32'h0);
    tick();
    chk("t5_recov_state", {29'd0, state}, 32'h1);
    chk("t5_recov_lock",  {31'd0, lock_err}, 32'h1);
    chk("t5_recov_valid", {31'd0, mif.m_valid}, 32'h0);
    tick();
    chk("t5_recov_lock_clr", {31'd0, lock_err}, 32'h0);

    // Reset during back-pressure discards the pending word
    mif.m_ready = 1'b0;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    tick();
    chk("t6_pend_valid", {31'd0, mif.m_valid}, 32'h1);
    chk("t6_pend_state", {29'd0, state}, 32'h4);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", {31'd0, mif.m_valid}, 32'h0);
    chk("t6_rst_state", {29'd0, state}, 32'h1);
    tick();
    rst = 1'b0;
    mif.m_ready = 1'b1;
    tick();
    push1(1'b1, 1'b0);
    push1(1'b0, 1'b0);
    enable = 1'b1;
    repeat (2) tick();
    enable = 1'b0;
    repeat (2) tick();

    chk("q1_drained", q1.size(), 32'h0);
    chk("q4_drained", q4.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
